// File: rtl/mcb_port_arb_pkg.sv
// mcb_port_arb_pkg: shared state encodings, default burst length and sizing helper
package mcb_port_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BB = 2'b01, ST_BURST = 2'b10} arb_state_t;
    localparam int PBL_DEF = 4;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/mcb_rr_pick.sv
// mcb_rr_pick: rotate-priority encoder, first requester at or above ptr wins
module mcb_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          vld
);
    logic [N-1:0] rot;
    logic [PW-1:0] off;
    logic [PW:0] sum;
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = PW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        vld = |req;
        idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
        gnt = vld ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/mcb_port_arb.sv
// mcb_port_arb: round-robin port arbiter and burst sequencer in front of the MCB command FSM
module mcb_port_arb
    import mcb_port_arb_pkg::*;
#(
    parameter int NPORT  = 4,
    parameter int ADDR_W = 22,
    parameter int BLEN_W = 6,
    parameter int PBL    = PBL_DEF,
    localparam int PW    = clog2(NPORT)
) (
    input  logic                    mcb_clk,
    input  logic                    mcb_rst_n,
    input  logic                    mcb_sclr_n,
    input  logic                    i_ready,
    input  logic [NPORT-1:0]        p_req,
    input  logic [NPORT-1:0]        p_dir,
    input  logic [NPORT*ADDR_W-1:0] p_addr,
    input  logic [NPORT*BLEN_W-1:0] p_blen_m1,
    output logic [NPORT-1:0]        p_gnt,
    output logic [NPORT-1:0]        p_done,
    input  logic                    c_ready,
    input  logic                    c_act,
    input  logic                    c_rd,
    input  logic                    c_wr,
    input  logic                    c_rda,
    input  logic                    c_wra,
    output logic                    mcb_bb,
    output logic                    c_bst_dir,
    output logic                    c_bst_last,
    output logic [ADDR_W-1:0]       mcb_addr,
    output logic [PW-1:0]           mcb_port
);
    arb_state_t state, state_nx;
    logic [PW-1:0] ptr, owner, pick_idx;
    logic [NPORT-1:0] gnt, done, pick_gnt;
    logic pick_vld, dir, sel_dir, clr, ld, step, fin;
    logic [ADDR_W-1:0] addr, sel_addr;
    logic [BLEN_W-1:0] rem, sel_blen;
    logic unused_c_ready;

    assign unused_c_ready = c_ready;
    assign clr = !mcb_sclr_n || !i_ready;

    mcb_rr_pick #(.N(NPORT), .PW(PW)) u_pick (
        .req(p_req),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .vld(pick_vld)
    );

    always_comb begin
        sel_dir = 1'b0;
        sel_addr = '0;
        sel_blen = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_dir = p_dir[i];
                sel_addr = p_addr[i*ADDR_W +: ADDR_W];
                sel_blen = p_blen_m1[i*BLEN_W +: BLEN_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        ld = 1'b0;
        step = 1'b0;
        fin = 1'b0;
        case (state)
            ST_IDLE: if (pick_vld) begin
                ld = 1'b1;
                state_nx = ST_BB;
            end
            ST_BB: if (c_act) state_nx = ST_BURST;
            ST_BURST: if (c_rda || c_wra) begin
                fin = 1'b1;
                state_nx = ST_IDLE;
            end else begin
                step = (c_rd || c_wr) && (rem != '0);
            end
            default: state_nx = ST_IDLE;
        endcase
        if (clr) begin
            state_nx = ST_IDLE;
            ld = 1'b0;
            step = 1'b0;
            fin = 1'b0;
        end
    end

    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            state <= ST_IDLE;
            ptr <= '0;
            owner <= '0;
            gnt <= '0;
            done <= '0;
            dir <= 1'b0;
            addr <= '0;
            rem <= '0;
        end else begin
            state <= state_nx;
            done <= fin ? gnt : '0;
            // an abort keeps ptr so the interrupted port wins again
            if (clr) begin
                owner <= '0;
                gnt <= '0;
                dir <= 1'b0;
                addr <= '0;
                rem <= '0;
            end else if (ld) begin
                owner <= pick_idx;
                gnt <= pick_gnt;
                dir <= sel_dir;
                addr <= sel_addr;
                rem <= sel_blen;
            end else if (step) begin
                addr <= addr + ADDR_W'(PBL);
                rem <= rem - BLEN_W'(1);
            end else if (fin) begin
                gnt <= '0;
                ptr <= (owner == PW'(NPORT - 1)) ? '0 : owner + PW'(1);
            end
        end
    end

    assign p_gnt = gnt;
    assign p_done = done;
    assign mcb_bb = (state == ST_BB);
    assign c_bst_dir = dir;
    assign c_bst_last = (state != ST_IDLE) && (rem == '0);
    assign mcb_addr = addr;
    assign mcb_port = owner;
endmodule

// File: doc/mcb_port_arb.md
Name: mcb_port_arb

Overview:
- Multi-port round-robin arbiter and burst sequencer in front of the MCB command FSM.
- Selects one requester, latches its address, direction and burst count, and asserts mcb_bb.
- Tracks each column command (rd/wr/rda/wra) the FSM issues, and drives c_bst_dir and c_bst_last so the FSM closes the row on the final burst.
- Signals completion back to the owning port.

Parameters:
- NPORT, 4, number of requesters (2..8).
- ADDR_W, 22, column-granular byte-lane address width.
- BLEN_W, 6, width of per-request burst count field (bursts minus 1).
- PBL, 4, SDRAM burst length; address advance per column command.

Ports:
- mcb_clk  in  1  controller clock.
- mcb_rst_n  in  1  asynchronous active-low reset.
- mcb_sclr_n  in  1  synchronous clear, active low.
- i_ready  in  1  SDRAM init complete.
- p_req  in  NPORT  per-port request level.
- p_dir  in  NPORT  per-port direction; 1=read, 0=write.
- p_addr  in  NPORT*ADDR_W  per-port start address, packed port0 LSBs.
- p_blen_m1  in  NPORT*BLEN_W  per-port burst count minus 1.
- p_gnt  out  NPORT  one-hot ownership level.
- p_done  out  NPORT  one-cycle completion pulse to owner.
- c_ready  in  1  FSM idle/ready.
- c_act, c_rd, c_wr, c_rda, c_wra  in  1 each  FSM command strobes.
- mcb_bb  out  1  burst begin request to FSM.
- c_bst_dir  out  1  latched direction.
- c_bst_last  out  1  current burst is the final one.
- mcb_addr  out  ADDR_W  column address of current burst.
- mcb_port  out  clog2(NPORT)  owner index, for datapath steering.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0. mcb_sclr_n=0 or i_ready=0 has the same effect synchronously.
- States:
  - IDLE: if any p_req, pick a winner starting at pointer, wrapping upward. Register p_gnt, mcb_port, c_bst_dir, mcb_addr and rem=p_blen_m1 of the winner. Set mcb_bb=1 and go to BB. The grant is visible one cycle after the request is sampled.
  - BB: hold mcb_bb=1. On c_act, clear mcb_bb next cycle and go to BURST. A refresh taken by the FSM while mcb_bb is high is harmless: stay in BB.
  - BURST: on c_rd or c_wr, mcb_addr += PBL and rem -= 1. On c_rda or c_wra, pulse p_done[owner] next cycle, clear p_gnt, set pointer = (owner+1) mod NPORT, and go to IDLE.
- c_bst_last is combinational: (rem==0) while in BB or BURST, else 0. It is therefore valid when the FSM samples it in act/trcd and rd_w/wr_w.
- Width rules: mcb_addr increments modulo 2^ADDR_W. Requesters guarantee a request never crosses a row; the arbiter does not check this.
- Boundaries:
  - blen_m1=0: single burst; c_bst_last=1 from the BB cycle onward.
  - blen_m1 = all ones: 2^BLEN_W bursts.
  - Unexpected c_rd/c_wr while rem==0: ignored, with no underflow.
  - Strobes outside BB/BURST: ignored.
- Abort (mcb_sclr_n=0 or i_ready=0 mid-operation): return to IDLE, drop p_gnt and mcb_bb, do not pulse p_done, and leave the pointer unchanged, so the same port wins again.
- The requester samples nothing after grant. Fields are latched at grant and may change while owned. p_req must drop on p_done or it re-arbitrates next cycle.
- No new grant is issued in the p_done cycle; minimum gap between ownerships is 1 cycle.

Decomposition:
- Shared parameter include / package: state encodings (IDLE=2'b00, BB=2'b01, BURST=2'b10), PBL default, and a clog2 function; reused by the FSM and datapath.
- One sub-module, mcb_rr_pick: combinational rotate-priority encoder (req vector, pointer -> one-hot grant, index, valid).

Test Plan:
- Single read, port1, addr=0x100, blen_m1=2:
  - Expect mcb_bb one cycle after request, drop after c_act.
  - Expect addr 0x100, 0x104, 0x108 across two c_rd then c_rda.
  - c_bst_last=1 after the second c_rd; p_done[1] one pulse; pointer=2.
- All four ports requesting continuously: grants in order 0,1,2,3,0 and each p_done precedes the next p_gnt by exactly one cycle.
- blen_m1=0 write on port3: c_bst_last=1 at the BB cycle, FSM issues c_wra directly, p_done[3], pointer wraps to 0.
- Refresh while in BB (c_ready low, no c_act for 10 cycles): mcb_bb stays 1, no state change, then normal completion.
- mcb_sclr_n low during BURST with rem=3: p_gnt=0, mcb_bb=0, no p_done, same port re-granted after release.
- Spurious c_rd in IDLE and an extra c_rd at rem=0: no address or count change.
